result_bcd_converter: RTL and testbench

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

---
 rtl/result_bcd_converter.sv | 113 +++++++++++
 tb/tb_result_bcd_converter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for a 16-bit ALU result.
// Runs one double-dabble iteration per clock and publishes the result with a one-cycle done pulse.
module result_bcd_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  out,
    input  logic [7:0]  extended_out,
    input  logic        overflow,
    input  logic        carry,
    input  logic        signed_mode,
    output logic [19:0] bcd,
    output logic        negative,
    output logic        ovf_flag,
    output logic        carry_flag,
    output logic        busy,
    output logic        done
);

    localparam int NUM_DIGITS = 5;
    localparam int ITERS      = 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]  state;
    logic [19:0] scratch;
    logic [15:0] mag;
    logic [3:0]  cnt;
    logic        sign_q;
    logic        ovf_q;
    logic        carry_q;

    logic [15:0] operand;
    logic        neg_in;
    logic [15:0] mag_in;
    logic [19:0] adj;
    logic [19:0] nxt_scratch;
    logic [15:0] nxt_mag;

    assign operand = {extended_out, out};
    assign neg_in  = signed_mode & operand[15];
    // 0x8000 negates to itself, which read unsigned is exactly 32768.
    assign mag_in  = neg_in ? (~operand + 16'd1) : operand;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    assign nxt_scratch = {adj[18:0], mag[15]};
    assign nxt_mag     = {mag[14:0], 1'b0};
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scratch    <= '0;
            mag        <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            carry_q    <= 1'b0;
            bcd        <= '0;
            negative   <= 1'b0;
            ovf_flag   <= 1'b0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mag     <= mag_in;
                        sign_q  <= neg_in;
                        ovf_q   <= overflow;
                        carry_q <= carry;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch <= nxt_scratch;
                    mag     <= nxt_mag;
                    cnt     <= cnt + 4'd1;
                    // Last iteration: publish the freshly shifted digits in the same edge.
                    if (cnt == 4'(ITERS - 1)) begin
                        bcd        <= nxt_scratch;
                        negative   <= sign_q;
                        ovf_flag   <= ovf_q;
                        carry_flag <= carry_q;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: hand-computed BCD results, flag capture,
// start-ignore, mid-conversion reset and back-to-back operation.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  out;
    logic [7:0]  extended_out;
    logic        overflow;
    logic        carry;
    logic        signed_mode;
    logic [19:0] bcd;
    logic        negative;
    logic        ovf_flag;
    logic        carry_flag;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    result_bcd_converter dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .out          (out),
        .extended_out (extended_out),
        .overflow     (overflow),
        .carry        (carry),
        .signed_mode  (signed_mode),
        .bcd          (bcd),
        .negative     (negative),
        .ovf_flag     (ovf_flag),
        .carry_flag   (carry_flag),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge, scrambles the don't-care inputs, then waits (bounded) for done.
    task automatic convert(input logic [15:0] op, input logic sm, input logic ov, input logic cy,
                           output int lat);
        out          = op[7:0];
        extended_out = op[15:8];
        signed_mode  = sm;
        overflow     = ov;
        carry        = cy;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        out          = ~op[7:0];
        extended_out = ~op[15:8];
        signed_mode  = ~sm;
        overflow     = 1'b0;
        carry        = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first;
        int d0, d1, d2;
        int lowcnt;

        reset = 1'b1; start = 1'b0; out = 8'h00; extended_out = 8'h00;
        overflow = 1'b0; carry = 1'b0; signed_mode = 1'b0;
        tick(); tick();
        chk("rst_bcd",   32'(bcd), 32'h0);
        chk("rst_neg",   32'(negative), 32'h0);
        chk("rst_ovf",   32'(ovf_flag), 32'h0);
        chk("rst_carry", 32'(carry_flag), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        reset = 1'b0;

        // 0x00FF unsigned
        convert(16'h00FF, 1'b0, 1'b0, 1'b0, lat);
        chk("ff_lat",  32'(lat), 32'd16);
        chk("ff_bcd",  32'(bcd), 32'h00255);
        chk("ff_neg",  32'(negative), 32'h0);
        chk("ff_busy", 32'(busy), 32'h1);
        tick();
        chk("ff_done_clr", 32'(done), 32'h0);
        chk("ff_idle",     32'(busy), 32'h0);

        convert(16'hFFFF, 1'b0, 1'b0, 1'b0, lat);
        chk("u65535_lat", 32'(lat), 32'd16);
        chk("u65535_bcd", 32'(bcd), 32'h65535);
        chk("u65535_neg", 32'(negative), 32'h0);
        tick();

        convert(16'hFFFF, 1'b1, 1'b0, 1'b0, lat);
        chk("sm1_bcd", 32'(bcd), 32'h00001);
        chk("sm1_neg", 32'(negative), 32'h1);
        tick();

        convert(16'h8000, 1'b1, 1'b0, 1'b0, lat);
        chk("s8000_bcd", 32'(bcd), 32'h32768);
        chk("s8000_neg", 32'(negative), 32'h1);
        tick();

        // flags high only at the accepting edge
        convert(16'h1234, 1'b0, 1'b1, 1'b1, lat);
        chk("flag_bcd",   32'(bcd), 32'h04660);
        chk("flag_ovf",   32'(ovf_flag), 32'h1);
        chk("flag_carry", 32'(carry_flag), 32'h1);
        tick();

        convert(16'h0000, 1'b0, 1'b0, 1'b0, lat);
        chk("zero_bcd",   32'(bcd), 32'h00000);
        chk("zero_ovf",   32'(ovf_flag), 32'h0);
        chk("zero_carry", 32'(carry_flag), 32'h0);
        tick();

        convert(16'h7FFF, 1'b1, 1'b0, 1'b0, lat);
        chk("s7fff_bcd", 32'(bcd), 32'h32767);
        chk("s7fff_neg", 32'(negative), 32'h0);
        tick();

        // start re-pulsed mid-conversion with a different operand is ignored
        out = 8'h64; extended_out = 8'h00; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; out = 8'h39; extended_out = 8'h30;
        pulses = 0; first = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 8) chk("hold_bcd", 32'(bcd), 32'h32767);
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
            start = (k == 4);
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_lat",    32'(first), 32'd16);
        chk("ign_bcd",    32'(bcd), 32'h00100);

        // asynchronous reset at iteration 8
        out = 8'h99; extended_out = 8'h09; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_bcd",  32'(bcd), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        pulses = 0;
        repeat (3) begin
            tick();
            if (done) pulses++;
        end
        reset = 1'b0;
        repeat (12) begin
            tick();
            if (done) pulses++;
        end
        chk("arst_nodone", 32'(pulses), 32'd0);
        chk("arst_bcd_hold", 32'(bcd), 32'h0);
        convert(16'h0001, 1'b0, 1'b0, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd16);
        chk("post_rst_bcd", 32'(bcd), 32'h00001);
        tick();

        // start held high: back-to-back conversions
        out = 8'hFF; extended_out = 8'h00; signed_mode = 1'b0; start = 1'b1;
        tick();
        d0 = 0; d1 = 0; d2 = 0; lowcnt = 0; pulses = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (done) begin
                pulses++;
                if (pulses == 1) d0 = t;
                else if (pulses == 2) d1 = t;
                else if (pulses == 3) d2 = t;
            end
            if (!busy && t > 16 && t < 34) lowcnt++;
        end
        start = 1'b0;
        chk("b2b_first", 32'(d0), 32'd16);
        chk("b2b_gap1",  32'(d1 - d0), 32'd18);
        chk("b2b_gap2",  32'(d2 - d1), 32'd18);
        chk("b2b_idle",  32'(lowcnt), 32'd1);
        chk("b2b_bcd",   32'(bcd), 32'h00255);
        repeat (20) tick();
        chk("b2b_stop",  32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
